wb_queue: RTL

Writeback queue between the execution lanes and the register file write ports of the in-order superscalar core. It accepts completed results (destination register, data) from IN_PORTS lanes per cycle and buffers them in a FIFO. It drains up to WRITE_PORTS entries per cycle onto the register file write ports in program order. It also forwards the youngest buffered value for any register being read, so decode never sees stale register file contents.

---
 rtl/wb_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// Writeback FIFO between the execution lanes and the register file write ports.
// Drains in program order and forwards the youngest buffered value to decode.
module wb_queue #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 32,
   parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
   parameter int IN_PORTS    = 2,
   parameter int WRITE_PORTS = 1,
   parameter int READ_PORTS  = 2,
   parameter int DEPTH       = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid         [IN_PORTS-1:0],
   input  logic [ADDR_WIDTH-1:0]         in_addr          [IN_PORTS-1:0],
   input  logic [DATA_WIDTH-1:0]         in_data          [IN_PORTS-1:0],
   output logic                          in_ready,
   output logic [ADDR_WIDTH-1:0]         write_addrs      [WRITE_PORTS-1:0],
   output logic [DATA_WIDTH-1:0]         write_data       [WRITE_PORTS-1:0],
   output logic                          write_reg_enable [WRITE_PORTS-1:0],
   input  logic [ADDR_WIDTH-1:0]         rs1s             [READ_PORTS-1:0],
   input  logic [ADDR_WIDTH-1:0]         rs2s             [READ_PORTS-1:0],
   output logic                          fwd_hit_rs1      [READ_PORTS-1:0],
   output logic                          fwd_hit_rs2      [READ_PORTS-1:0],
   output logic [DATA_WIDTH-1:0]         fwd_data_rs1     [READ_PORTS-1:0],
   output logic [DATA_WIDTH-1:0]         fwd_data_rs2     [READ_PORTS-1:0],
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic                          empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_WIDTH-1:0] mem_addr_r [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data_r [DEPTH];
   logic [PTR_W-1:0]      head_r;
   logic [PTR_W-1:0]      tail_r;
   logic [CNT_W-1:0]      count_r;

   logic [IN_PORTS-1:0]   keep_s;
   logic [PTR_W-1:0]      slot_s [IN_PORTS];
   logic [CNT_W-1:0]      npush_s;
   logic [CNT_W-1:0]      npop_s;

   // Youngest occupied entry matching a; draining entries are still visible, index 0 never hits.
   function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] a);
      logic [DATA_WIDTH:0] res;
      logic [PTR_W-1:0]    idx;
      res = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_r + PTR_W'(k);
         if (k < int'(count_r) && a != '0 && mem_addr_r[idx] == a) begin
            res = {1'b1, mem_data_r[idx]};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign in_ready = (int'(count_r) + IN_PORTS) <= DEPTH;
   assign count    = count_r;
   assign empty    = (count_r == '0);

   // Compact the kept lanes onto consecutive tail slots, lane 0 oldest.
   always_comb begin
      npush_s = '0;
      for (int i = 0; i < IN_PORTS; i++) begin
         keep_s[i] = in_ready && in_valid[i] && (in_addr[i] != '0);
         slot_s[i] = tail_r + PTR_W'(npush_s);
         if (keep_s[i]) begin
            npush_s = npush_s + CNT_W'(1);
         end else begin
            npush_s = npush_s;
         end
      end
   end

   // Drain count and register file write port presentation.
   always_comb begin
      npop_s = (int'(count_r) < WRITE_PORTS) ? count_r : CNT_W'(WRITE_PORTS);
      for (int p = 0; p < WRITE_PORTS; p++) begin
         if (p < int'(npop_s)) begin
            write_reg_enable[p] = 1'b1;
            write_addrs[p]      = mem_addr_r[head_r + PTR_W'(p)];
            write_data[p]       = mem_data_r[head_r + PTR_W'(p)];
         end else begin
            write_reg_enable[p] = 1'b0;
            write_addrs[p]      = '0;
            write_data[p]       = '0;
         end
      end
   end

   // Forwarding lookups for both decode source operands.
   always_comb begin
      for (int r = 0; r < READ_PORTS; r++) begin
         {fwd_hit_rs1[r], fwd_data_rs1[r]} = lookup(rs1s[r]);
         {fwd_hit_rs2[r], fwd_data_rs2[r]} = lookup(rs2s[r]);
      end
   end

   // Pointer and occupancy state; reset discards buffered entries and the offered lanes.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         head_r  <= head_r + PTR_W'(npop_s);
         tail_r  <= tail_r + PTR_W'(npush_s);
         count_r <= count_r + npush_s - npop_s;
      end
   end

   // Entry storage; stale contents are harmless since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < IN_PORTS; i++) begin
            if (keep_s[i]) begin
               mem_addr_r[slot_s[i]] <= in_addr[i];
               mem_data_r[slot_s[i]] <= in_data[i];
            end
         end
      end
   end

endmodule
